// File: rtl/opamp_with_frac.sv
// opamp_with_frac: fixed-point non-inverting op-amp stage with finite slew, plus 100 kHz sample clock divider.
// Optional macro GAIN_BUG_EN adds a gain_bug input that overrides CL_GAIN.
module opamp_with_frac #(
   parameter int          CLK_DIV    = 1000,
   parameter int          CL_GAIN    = 2,
   parameter int          SLEW_SHIFT = 3,
   parameter logic [31:0] RAIL_Q     = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] non_inv,
`ifdef GAIN_BUG_EN
   input  logic [10:0] gain_bug,
`endif
   output logic [31:0] square_out,
   output logic        clk_100k
);
   localparam int HALF = CLK_DIV / 2;
   localparam int CW   = $clog2(HALF) > 0 ? $clog2(HALF) : 1;

   logic [CW-1:0] div_cnt_q, div_cnt_d;
   logic          clk_100k_q, clk_100k_d;

   always_comb begin
      div_cnt_d  = (div_cnt_q == CW'(HALF - 1)) ? '0 : div_cnt_q + 1'b1;
      clk_100k_d = (div_cnt_q == CW'(HALF - 1)) ? ~clk_100k_q : clk_100k_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         div_cnt_q  <= '0;
         clk_100k_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         clk_100k_q <= clk_100k_d;
      end

   logic [10:0]        gain;
   logic [26:0]        prod;
   logic [42:0]        tgt_full;
   logic [31:0]        target, y_q, y_d;
   logic signed [33:0] err, step_raw, step, y_sum;

`ifdef GAIN_BUG_EN
   assign gain = (gain_bug == 11'd0) ? 11'd1 : gain_bug;
`else
   assign gain = 11'(CL_GAIN);
`endif

   // Target is formed at full width so large gains clip instead of wrapping.
   always_comb begin
      prod     = 27'(non_inv) * 27'(gain);
      tgt_full = {prod, 16'h0000};
      target   = (tgt_full > 43'(RAIL_Q)) ? RAIL_Q : tgt_full[31:0];
      err      = $signed({2'b00, target}) - $signed({2'b00, y_q});
      step_raw = err >>> SLEW_SHIFT;
      step     = (err != 34'sd0 && step_raw == 34'sd0) ? (err[33] ? -34'sd1 : 34'sd1) : step_raw;
      y_sum    = $signed({2'b00, y_q}) + step;
      y_d      = y_sum[33] ? '0 : ((y_sum > $signed({2'b00, RAIL_Q})) ? RAIL_Q : y_sum[31:0]);
   end

   always_ff @(posedge clk_100k_q or negedge reset_n)
      if (!reset_n) y_q <= '0;
      else          y_q <= y_d;

   assign square_out = y_q;
   assign clk_100k   = clk_100k_q;
endmodule

// File: tb/tb_opamp_with_frac.sv
// tb_opamp_with_frac: directed bench with a per-tick reference model and a queue of settled-value expectations.
// Uses a short divider so the whole run stays small; GAIN_BUG_EN enables the gain override steps.
`timescale 1ns/1ps
module tb_opamp_with_frac;
   localparam int          DIV  = 10;
   localparam int          HALF = DIV / 2;
   localparam longint      RAIL = 64'h0000_0000_FFFF_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] non_inv = 16'd36;
   logic [31:0] square_out;
   logic        clk_100k;
`ifdef GAIN_BUG_EN
   logic [10:0] gain_bug = 11'd2;
`endif

   int          tests = 0;
   int          fails = 0;
   longint      ym;
   logic [31:0] expq[$];
   logic [31:0] prev, exp_v;
   realtime     t_rel, t1, t2, t3;

   opamp_with_frac #(.CLK_DIV(DIV)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .non_inv(non_inv),
`ifdef GAIN_BUG_EN
      .gain_bug(gain_bug),
`endif
      .square_out(square_out),
      .clk_100k(clk_100k)
   );

   always #5 clk = ~clk;

   function automatic longint model_step(longint y, longint ni, longint g);
      longint tgt, e, s;
      tgt = ni * g * 65536;
      if (tgt > RAIL) tgt = RAIL;
      e = tgt - y;
      s = e >>> 3;
      if (e != 0 && s == 0) s = (e > 0) ? 1 : -1;
      y = y + s;
      if (y < 0) y = 0;
      if (y > RAIL) y = RAIL;
      return y;
   endfunction

   function automatic longint model_gain();
`ifdef GAIN_BUG_EN
      return (gain_bug == 0) ? 1 : longint'(gain_bug);
`else
      return 2;
`endif
   endfunction

   always @(posedge clk_100k or negedge reset_n)
      if (!reset_n) ym <= 0;
      else          ym <= model_step(ym, longint'(non_inv), model_gain());

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // dir: +1 must not fall, -1 must not rise, 0 must hold.
   task automatic run_ticks(input int n, input int dir);
      prev = square_out;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_100k);
         #1;
         chk("model", square_out, 32'(ym));
         if (dir > 0)      chk("mono_up", 32'(square_out >= prev), 32'd1);
         else if (dir < 0) chk("mono_down", 32'(square_out <= prev), 32'd1);
         else              chk("hold", square_out, prev);
         prev = square_out;
      end
   endtask

   task automatic settle(input string tag, input int n, input int dir);
      run_ticks(n, dir);
      exp_v = expq.pop_front();
      chk(tag, square_out, exp_v);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #50;
      chk("reset_out", square_out, 32'h0);
      chk("reset_clk", 32'(clk_100k), 32'h0);
      #50;
      reset_n = 1'b1;
      t_rel = $realtime;
      @(posedge clk_100k);
      t1 = $realtime;
      chk("first_rise", 32'(int'(t1 - t_rel)), 32'(5 + (HALF - 1) * 10));
      @(negedge clk_100k);
      t2 = $realtime;
      @(posedge clk_100k);
      t3 = $realtime;
      chk("high_time", 32'(int'(t2 - t1)), 32'(HALF * 10));
      chk("period", 32'(int'(t3 - t1)), 32'(DIV * 10));
      #1;
      expq.push_back(32'h0048_0000);
      run_ticks(180, 1);
      run_ticks(20, 0);
      exp_v = expq.pop_front();
      chk("settle_36", square_out, exp_v);
      non_inv = 16'd10;
      expq.push_back(32'h0014_0000);
      settle("settle_10", 110, -1);
      non_inv = 16'd0;
      expq.push_back(32'h0000_0000);
      settle("settle_0", 130, -1);
      non_inv = 16'd40000;
      expq.push_back(32'hFFFF_0000);
      settle("clip_rail", 200, 1);
      run_ticks(5, 0);
      non_inv = 16'd1000;
      run_ticks(10, -1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midreset_out", square_out, 32'h0);
      chk("midreset_clk", 32'(clk_100k), 32'h0);
      #30;
      @(negedge clk);
      reset_n = 1'b1;
      t_rel = $realtime;
      @(posedge clk_100k);
      chk("rerise", 32'(int'($realtime - t_rel)), 32'(5 + (HALF - 1) * 10));
      #1;
      expq.push_back(32'h07D0_0000);
      settle("reconverge", 200, 1);
`ifdef GAIN_BUG_EN
      gain_bug = 11'd5;
      non_inv = 16'd36;
      expq.push_back(32'h00B4_0000);
      settle("gain_bug5", 200, -1);
      gain_bug = 11'd0;
      expq.push_back(32'h0024_0000);
      settle("gain_bug0", 200, -1);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
